avalon_st_image_source: RTL and testbench
=========================================

Name: avalon_st_image_source

Overview:
Avalon-ST source that feeds gray-scale frames into the Sobel filter's pixel input. A host preloads one frame into an internal buffer through a simple write port. On go_i, the block pulses start_o and then streams the frame in raster order with valid/ready handshake and sop/eop framing. It is the transmitter end of the stream interface that the Sobel block consumes.

Parameters:
IMG_X_SIZE, 100, pixels per row
IMG_Y_SIZE, 100, rows per frame
PIX_N (local), IMG_X_SIZE*IMG_Y_SIZE, pixels per frame
ADDR_W (local), clog2(PIX_N), buffer address width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
wr_en_i  in  1  host buffer write strobe
wr_addr_i  in  ADDR_W  raster address (row*IMG_X_SIZE+col)
wr_data_i  in  8  gray pixel to store
go_i  in  1  request to transmit the buffered frame
ready_i  in  1  sink ready, zero ready-latency
data_o  out  8  streamed pixel
valid_o  out  1  data_o valid
sop_o  out  1  first pixel of frame, qualified by valid_o
eop_o  out  1  last pixel of frame, qualified by valid_o
start_o  out  1  one-cycle pulse to the downstream start input
busy_o  out  1  high from go acceptance through DONE
done_o  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: all outputs 0, state IDLE, pixel counter 0. Buffer contents are not cleared.
- Buffer: PIX_N x 8 synchronous RAM with 1-cycle read latency.
  - Write when wr_en_i=1, busy_o=0 and wr_addr_i<PIX_N. Otherwise the write is dropped.
- FSM states: IDLE, START, STREAM, DONE.
  - IDLE: busy_o=0. If go_i=1 at edge N, go to START.
  - START (cycle N+1): start_o=1, busy_o=1, RAM read of addr 0 issued, then go to STREAM.
  - STREAM: valid_o=1 from cycle N+2 with pixel 0 and sop_o=1.
    - A beat transfers on any edge where valid_o=1 and ready_i=1.
    - After a transfer, the next pixel is presented the following cycle. With ready_i held high, pixel k appears at cycle N+2+k (full throughput, no bubbles).
    - While valid_o=1 and ready_i=0, data_o, sop_o and eop_o hold stable. valid_o never drops mid-frame.
    - sop_o=1 only for pixel 0. eop_o=1 only for pixel PIX_N-1.
    - When the last beat transfers, go to DONE.
  - DONE: valid_o=0, done_o=1 for one cycle, busy_o=1, then IDLE.
- Counter: ADDR_W bits, 0..PIX_N-1, no wrap within a frame. It resets to 0 on frame start.
- go_i while busy_o=1 is ignored; it is not queued.
- go_i and wr_en_i in the same IDLE cycle: the write commits, and the streamed frame includes the new value (first read issues in START).
- PIX_N=1: the single beat has sop_o=eop_o=1.
- rst_i mid-frame: next cycle all outputs 0, state IDLE. The partial frame is abandoned with no eop. The next go_i restarts at pixel 0.
- Outputs are registered. No combinational path from ready_i to valid_o or data_o. The ready_i-to-RAM-address path is allowed.

Test Plan:
- 4x3 frame, buffer loaded with addr+0x10, go_i at cycle 5, ready_i=1 -> start_o=1 at cycle 6; valid_o with data 0x10..0x1B at cycles 7..18; sop at 7, eop at 18; done_o at 19; busy_o low at 20.
- Same frame, ready_i toggling 1,0,0,1,... -> sequence 0x10..0x1B delivered exactly once each, in order. data_o/sop_o/eop_o stable during every stall; valid_o never drops mid-frame.
- go_i pulsed again during STREAM, and wr_en_i to addr 3 with 0xFF during STREAM -> no second frame and no buffer change; a later frame still shows 0x13 at beat 3.
- Write to addr 12 (out of range for 4x3) -> ignored; frame unchanged. Write 0xAA to addr 0 in the same cycle as go_i -> first beat 0xAA with sop.
- rst_i asserted after beat 5 -> next cycle valid_o=busy_o=0. A new go_i streams from pixel 0 with sop_o=1, and buffer data is retained.
- IMG_X_SIZE=IMG_Y_SIZE=1, buffer 0x7E -> single beat 0x7E with sop_o=eop_o=1, then done_o.

Source files
------------

// File: rtl/avalon_st_image_source.sv
// Avalon-ST gray-scale frame source: a host preloads one frame into a local RAM,
// and on go_i the frame is streamed in raster order with sop/eop framing.
module avalon_st_image_source #(
  parameter int IMG_X_SIZE = 100,
  parameter int IMG_Y_SIZE = 100,
  localparam int PIX_N     = IMG_X_SIZE * IMG_Y_SIZE,
  localparam int ADDR_W    = (PIX_N > 1) ? $clog2(PIX_N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              go_i,
  input  logic              ready_i,
  output logic [7:0]        data_o,
  output logic              valid_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);
  localparam logic [ADDR_W:0]   PIX_N_W   = (ADDR_W + 1)'(PIX_N);

  typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next, rd_addr;
  logic [7:0]        mem [PIX_N];
  logic              xfer;

  assign xfer = valid_o & ready_i;

  // The read address looks ahead on a transfer so the next pixel is ready
  // one cycle later; this is the only path from ready_i into the datapath.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    rd_addr    = cnt;
    unique case (state)
      IDLE: begin
        if (go_i) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        state_next = STREAM;
        cnt_next   = '0;
        rd_addr    = '0;
      end
      STREAM: begin
        if (xfer) begin
          if (cnt == LAST_ADDR) begin
            state_next = DONE;
          end else begin
            cnt_next = cnt + ADDR_W'(1);
            rd_addr  = cnt + ADDR_W'(1);
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the frame buffer is deliberately not reset; it keeps host data across rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_o && ({1'b0, wr_addr_i} < PIX_N_W)) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // All outputs are registered from the next-state decode.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
      sop_o   <= 1'b0;
      eop_o   <= 1'b0;
      start_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      data_o  <= mem[rd_addr];
      valid_o <= (state_next == STREAM);
      sop_o   <= (state_next == STREAM) && (cnt_next == '0);
      eop_o   <= (state_next == STREAM) && (cnt_next == LAST_ADDR);
      start_o <= (state_next == START);
      busy_o  <= (state_next != IDLE);
      done_o  <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_avalon_st_image_source.sv
// Scoreboard bench for avalon_st_image_source: a 4x3 instance for framing, stall,
// busy-write, reset-abort cases, and a 1x1 instance for the single-pixel frame.
module tb_avalon_st_image_source;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  // 4x3 instance
  logic       wr_en_i, go_i, ready_i;
  logic [3:0] wr_addr_i;
  logic [7:0] wr_data_i, data_o;
  logic       valid_o, sop_o, eop_o, start_o, busy_o, done_o;

  // 1x1 instance
  logic       wr_en1, go1;
  logic [0:0] wr_addr1;
  logic [7:0] wr_data1, data1;
  logic       valid1, sop1, eop1, start1, busy1, done1;

  avalon_st_image_source #(.IMG_X_SIZE(4), .IMG_Y_SIZE(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .go_i(go_i), .ready_i(ready_i), .data_o(data_o),
    .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o), .start_o(start_o),
    .busy_o(busy_o), .done_o(done_o));

  avalon_st_image_source #(.IMG_X_SIZE(1), .IMG_Y_SIZE(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en1), .wr_addr_i(wr_addr1),
    .wr_data_i(wr_data1), .go_i(go1), .ready_i(1'b1), .data_o(data1),
    .valid_o(valid1), .sop_o(sop1), .eop_o(eop1), .start_o(start1),
    .busy_o(busy1), .done_o(done1));

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t exp_q[$];
  logic [7:0] model [12];
  bit    in_frame = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the presented beat to the scoreboard head on every valid cycle,
  // so a stall that changes data/sop/eop is caught as well; pops on transfer.
  always @(negedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      in_frame = 1'b0;
    end else begin
      if (in_frame) check("valid_hold", valid_o, 1);
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("beat_data", data_o, exp_q[0].d);
          check("beat_sop", sop_o, exp_q[0].sop);
          check("beat_eop", eop_o, exp_q[0].eop);
          if (ready_i) begin
            void'(exp_q.pop_front());
            in_frame = !eop_o;
          end
        end
      end
    end
  end

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
    step();
    wr_en_i = 1'b0;
  endtask

  task automatic push_frame();
    for (int k = 0; k < 12; k++) exp_q.push_back('{d: model[k], sop: (k == 0), eop: (k == 11)});
  endtask

  // mode 0: ready high; 1: ready 1,0,0 repeating; 2: ready high plus go/write during STREAM.
  task automatic go_frame(input int mode, input bit wr0);
    bit got_done = 1'b0;
    if (wr0) begin
      model[0] = 8'hAA;
      wr_en_i = 1'b1; wr_addr_i = 4'd0; wr_data_i = 8'hAA;
    end
    push_frame();
    go_i = 1'b1;
    step();
    go_i = 1'b0; wr_en_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ready_i = (mode == 1) ? (i % 3 == 0) : 1'b1;
      if (mode == 2 && i == 3) begin
        go_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 4'd3; wr_data_i = 8'hFF;
      end
      step();
      go_i = 1'b0; wr_en_i = 1'b0;
      if (done_o) begin
        got_done = 1'b1;
        break;
      end
    end
    check("frame_done", got_done, 1);
    check("done_valid_low", valid_o, 0);
    step();
    check("busy_after_done", busy_o, 0);
    ready_i = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; go_i = 1'b0; ready_i = 1'b1;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0; go1 = 1'b0;
    step(); step();
    rst_i = 1'b0;
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_sop_eop", {sop_o, eop_o}, 0);
    check("rst_start_busy_done", {start_o, busy_o, done_o}, 0);

    for (int k = 0; k < 12; k++) begin
      model[k] = 8'(k + 8'h10);
      write(4'(k), model[k]);
    end

    // Test 1: exact timing with ready held high.
    push_frame();
    go_i = 1'b1;
    step();
    go_i = 1'b0;
    check("t1_start", start_o, 1);
    check("t1_busy_start", busy_o, 1);
    check("t1_valid_in_start", valid_o, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      check("t1_valid", valid_o, 1);
      check("t1_start_low", start_o, 0);
    end
    step();
    check("t1_done", done_o, 1);
    check("t1_valid_done", valid_o, 0);
    check("t1_busy_done", busy_o, 1);
    step();
    check("t1_busy_idle", busy_o, 0);
    check("t1_done_pulse", done_o, 0);
    check("t1_queue_empty", exp_q.size(), 0);

    // Test 2: back-pressure.
    go_frame(1, 1'b0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Test 3: go and write while busy are ignored.
    go_frame(2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t3_no_restart", {start_o, valid_o, busy_o}, 0);
      step();
    end
    go_frame(0, 1'b0);
    check("t3_queue_empty", exp_q.size(), 0);

    // Test 4: out-of-range write dropped; write with go lands in the frame.
    write(4'd12, 8'h55);
    go_frame(0, 1'b1);
    check("t4_queue_empty", exp_q.size(), 0);

    // Test 5: reset after beat 5 abandons the frame.
    push_frame();
    go_i = 1'b1;
    step();
    go_i = 1'b0;
    for (int k = 0; k < 7; k++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("t5_valid_after_rst", valid_o, 0);
    check("t5_busy_after_rst", busy_o, 0);
    check("t5_eop_after_rst", eop_o, 0);
    go_frame(0, 1'b0);
    check("t5_queue_empty", exp_q.size(), 0);

    // Test 6: single-pixel frame.
    wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_data1 = 8'h7E;
    step();
    wr_en1 = 1'b0; go1 = 1'b1;
    step();
    go1 = 1'b0;
    check("t6_start", start1, 1);
    step();
    check("t6_valid", valid1, 1);
    check("t6_data", data1, 8'h7E);
    check("t6_sop_eop", {sop1, eop1}, 2'b11);
    step();
    check("t6_done", done1, 1);
    check("t6_valid_low", valid1, 0);
    step();
    check("t6_busy_low", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
